// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int          WORD_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam int          QDEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DROP
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {PC, instruction} queue with flush; the head entry is held in
// its own register so decode sees a stable, registered output.
import fetch_pkg::*;

module fetch_fifo (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);

  localparam logic [1:0] Q_FULL = 2'(QDEPTH);

  fetch_entry_t r_head;
  fetch_entry_t r_tail;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != Q_FULL) || w_pop);

  // NOTE: only two entries, so the storage is reset like any other register;
  // this keeps the head output at zero out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_count <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments let head take the old tail while tail
      // takes the new word in the same edge.
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_data;
          else                 r_tail <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == Q_FULL) r_head <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: walks the PC, keeps one memory request in flight and
// queues returned words for decode; a redirect flushes and restarts fetch.
import fetch_pkg::*;

module instr_fetch #(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              MemReq,
  output logic [WORD_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [WORD_W-1:0] MemData,
  input  logic              Redirect,
  input  logic [WORD_W-1:0] RedirectPC,
  output logic              InstValid,
  output logic [WORD_W-1:0] Inst,
  output logic [WORD_W-1:0] InstPC,
  input  logic              InstReady
);

  localparam logic [1:0] Q_FULL = 2'(QDEPTH);

  state_t            r_state;
  state_t            w_state_next;
  logic [WORD_W-1:0] r_fetch_pc;
  logic [WORD_W-1:0] w_fetch_pc_next;
  logic [WORD_W-1:0] r_drop_addr;
  logic [WORD_W-1:0] w_drop_addr_next;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_count;
  logic [1:0]        w_count_after_push;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_data;

  assign w_pop              = InstValid && InstReady;
  assign w_count_after_push = w_pop ? w_count : w_count + 2'd1;
  assign w_push_data        = '{pc: r_fetch_pc, inst: MemData};

  fetch_fifo u_fifo (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (Redirect),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_fetch_pc  <= RESET_PC;
      r_drop_addr <= RESET_PC;
    end else begin
      r_state     <= w_state_next;
      r_fetch_pc  <= w_fetch_pc_next;
      r_drop_addr <= w_drop_addr_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_next     = r_state;
    w_fetch_pc_next  = r_fetch_pc;
    w_drop_addr_next = r_drop_addr;
    w_push           = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (Redirect) w_fetch_pc_next = RedirectPC;
        w_state_next = REQ;
      end
      REQ: begin
        if (Redirect) begin
          w_fetch_pc_next = RedirectPC;
          if (MemAck) begin
            w_state_next = REQ;
          end else begin
            // Memory keeps seeing the old address until it answers.
            w_state_next     = DROP;
            w_drop_addr_next = r_fetch_pc;
          end
        end else if (MemAck) begin
          w_push          = 1'b1;
          w_fetch_pc_next = r_fetch_pc + PC_STEP;
          w_state_next    = (w_count_after_push == Q_FULL) ? HOLD : REQ;
        end
      end
      HOLD: begin
        if (Redirect) begin
          w_fetch_pc_next = RedirectPC;
          w_state_next    = REQ;
        end else if (w_pop) begin
          w_state_next = REQ;
        end
      end
      DROP: begin
        if (Redirect) w_fetch_pc_next = RedirectPC;
        if (MemAck)   w_state_next    = REQ;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign MemReq    = (r_state == REQ) || (r_state == DROP);
  assign MemAddr   = (r_state == DROP) ? r_drop_addr : r_fetch_pc;
  assign InstValid = (w_count != 2'd0);
  assign Inst      = w_head.inst;
  assign InstPC    = w_head.pc;

endmodule
